digit_serial_core: RTL and testbench

//  Parametrised successor to the 8-bit bit-serial accumulator CPU core.

---
 rtl/digit_serial_core_pkg.sv | 41 ++++
 rtl/digit_serial_core_alu.sv | 32 +++
 rtl/digit_serial_core.sv | 133 +++++++++++++
 tb/tb_digit_serial_core.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/digit_serial_core_pkg.sv
// Shared opcodes, FSM encoding and opcode-class helpers for the digit-serial accumulator core.
package digit_serial_core_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OP_W-1:0] OP_ANDI = 4'h4;
  localparam logic [OP_W-1:0] OP_ORI  = 4'h5;
  localparam logic [OP_W-1:0] OP_XORI = 4'h6;
  localparam logic [OP_W-1:0] OP_RSV  = 4'h7;
  localparam logic [OP_W-1:0] OP_LD   = 4'h8;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h9;
  localparam logic [OP_W-1:0] OP_SUB  = 4'hA;
  localparam logic [OP_W-1:0] OP_AND  = 4'hB;
  localparam logic [OP_W-1:0] OP_OR   = 4'hC;
  localparam logic [OP_W-1:0] OP_XOR  = 4'hD;
  localparam logic [OP_W-1:0] OP_ST   = 4'hE;
  localparam logic [OP_W-1:0] OP_OUT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return ((op >= OP_ADDI) && (op <= OP_XORI)) || ((op >= OP_ADD) && (op <= OP_XOR));
  endfunction

  function automatic logic is_sub_op(input logic [OP_W-1:0] op);
    return (op == OP_SUBI) || (op == OP_SUB);
  endfunction

  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ADD) || is_sub_op(op);
  endfunction

endpackage

// File: rtl/digit_serial_core_alu.sv
// One DIGIT_W-wide ALU slice; carry in/out chain the slices across EXEC cycles.
module digit_serial_core_alu
  import digit_serial_core_pkg::*;
#(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  logic [OP_W-1:0]    op,
  output logic [DIGIT_W-1:0] y,
  output logic               cout
);

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   sum;

  // Subtraction is a + ~b + 1, the +1 arriving as the first digit's carry-in
  always_comb begin
    b_eff = is_sub_op(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + (DIGIT_W+1)'(cin);
    y     = sum[DIGIT_W-1:0];
    cout  = sum[DIGIT_W];
    case (op)
      OP_ANDI, OP_AND: begin y = a & b; cout = cin; end
      OP_ORI,  OP_OR:  begin y = a | b; cout = cin; end
      OP_XORI, OP_XOR: begin y = a ^ b; cout = cin; end
      default: ;
    endcase
  end

endmodule

// File: rtl/digit_serial_core.sv
// Accumulator CPU core: DATA_W datapath processed DIGIT_W bits per EXEC cycle, LSB digit first.
module digit_serial_core
  import digit_serial_core_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned DIGIT_W  = 1,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              busy,
  output logic              done,
  output logic              flag_c,
  output logic              flag_z,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] out_result,
  output logic              out_valid
);

  localparam int unsigned NDIG  = DATA_W / DIGIT_W;
  localparam int unsigned CNT_W = $clog2(NDIG) + 1;

  state_t              state, state_nxt;
  logic                accept, last;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   acc, a_sh, b_sh, a_nxt, b_sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [CNT_W-1:0]    cnt;
  logic                carry, alu_cout;
  logic [DIGIT_W-1:0]  alu_y;

  digit_serial_core_alu #(.DIGIT_W(DIGIT_W)) u_alu (
    .a    (a_sh[DIGIT_W-1:0]),
    .b    (b_sh[DIGIT_W-1:0]),
    .cin  (carry),
    .op   (op_q),
    .y    (alu_y),
    .cout (alu_cout)
  );

  assign b_sel   = instr_op[3] ? regs[instr_rs] : instr_imm;
  // Result digit enters at the top as the shadow shifts right
  assign a_nxt   = (a_sh >> DIGIT_W) | (DATA_W'(alu_y) << (DATA_W - DIGIT_W));
  assign acc_out = acc;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: if (instr_valid) begin
        accept    = 1'b1;
        state_nxt = is_alu_op(instr_op) ? ST_EXEC : ST_COMMIT;
      end
      ST_EXEC: if (cnt == CNT_W'(NDIG - 1)) begin
        last      = 1'b1;
        state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Architectural writes land on the edge entering COMMIT so they are visible alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      acc         <= '0;
      out_result  <= '0;
      op_q        <= OP_NOP;
      a_sh        <= '0;
      b_sh        <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      instr_ready <= (state_nxt == ST_IDLE);
      busy        <= (state_nxt != ST_IDLE);
      done        <= 1'b0;
      out_valid   <= 1'b0;
      if (accept) begin
        op_q  <= instr_op;
        a_sh  <= acc;
        b_sh  <= b_sel;
        cnt   <= '0;
        carry <= is_sub_op(instr_op);
        if (!is_alu_op(instr_op)) begin
          done <= 1'b1;
          case (instr_op)
            OP_LDI, OP_LD: begin
              acc    <= b_sel;
              flag_z <= (b_sel == '0);
            end
            OP_ST:  regs[instr_rs] <= acc;
            OP_OUT: begin
              out_result <= acc;
              out_valid  <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (state == ST_EXEC) begin
        a_sh  <= a_nxt;
        b_sh  <= b_sh >> DIGIT_W;
        carry <= alu_cout;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          done   <= 1'b1;
          acc    <= a_nxt;
          flag_z <= (a_nxt == '0);
          if (is_arith_op(op_q)) flag_c <= alu_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_core.sv
// Directed bench for digit_serial_core at DIGIT_W = 2, 1 and 8 (DATA_W = 8, NUM_REGS = 4).
module tb_digit_serial_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld;
  logic [3:0] op;
  logic [1:0] rs;
  logic [7:0] imm;
  logic [2:0] rdy, bsy, dn, fc, fz, ov;
  logic [7:0] acc  [3];
  logic [7:0] outr [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    digit_serial_core #(.DATA_W(8), .DIGIT_W(DW), .NUM_REGS(4)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (vld[g]),
      .instr_ready (rdy[g]),
      .instr_op    (op),
      .instr_rs    (rs),
      .instr_imm   (imm),
      .busy        (bsy[g]),
      .done        (dn[g]),
      .flag_c      (fc[g]),
      .flag_z      (fz[g]),
      .acc_out     (acc[g]),
      .out_result  (outr[g]),
      .out_valid   (ov[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction on instance d, return accept-to-done latency (bounded)
  task automatic exec(input int d, input logic [3:0] o, input logic [7:0] i,
                      input logic [1:0] r, output int lat);
    int w;
    w = 0;
    while (!rdy[d] && w < 20) begin @(posedge clk); #1; w++; end
    op = o; imm = i; rs = r; vld[d] = 1'b1;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    op = 4'($urandom); imm = 8'($urandom); rs = 2'($urandom);
    lat = 1;
    while (!dn[d] && lat < 30) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run(input int d, input logic [3:0] o, input logic [7:0] i,
                     input logic [1:0] r, input int exp_lat, input string tag);
    int lat;
    exec(d, o, i, r, lat);
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int ndone;
    int alu_lat;
    rst = 1'b1; vld = '0; op = '0; rs = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_acc",   32'(acc[0]),  32'h0);
    check("rst_ready", 32'(rdy[0]),  32'h1);
    check("rst_busy",  32'(bsy[0]),  32'h0);
    check("rst_done",  32'(dn[0]),   32'h0);
    check("rst_out",   32'(outr[0]), 32'h0);
    check("rst_flags", 32'({fc[0], fz[0]}), 32'h0);

    run(0, 4'h1, 8'h5A, 2'd0, 1, "ldi_lat");
    run(0, 4'h2, 8'hC3, 2'd0, 5, "addi_lat");
    check("addi_acc", 32'(acc[0]), 32'h1D);
    check("addi_cz",  32'({fc[0], fz[0]}), 32'b10);

    run(0, 4'h1, 8'h00, 2'd0, 1, "ldi0_lat");
    run(0, 4'h3, 8'h01, 2'd0, 5, "subi_lat");
    check("subi_acc", 32'(acc[0]), 32'hFF);
    check("subi_cz",  32'({fc[0], fz[0]}), 32'b00);

    run(0, 4'h1, 8'h10, 2'd0, 1, "ldi10_lat");
    run(0, 4'hE, 8'h00, 2'd2, 1, "st_r2_lat");
    run(0, 4'hA, 8'h00, 2'd2, 5, "sub_r2_lat");
    check("sub_acc", 32'(acc[0]), 32'h00);
    check("sub_cz",  32'({fc[0], fz[0]}), 32'b11);

    run(0, 4'h1, 8'hA5, 2'd0, 1, "ldia5_lat");
    run(0, 4'hE, 8'h00, 2'd3, 1, "st_r3_lat");
    run(0, 4'h1, 8'h00, 2'd0, 1, "ldi00_lat");
    check("ldi0_z", 32'(fz[0]), 32'h1);
    run(0, 4'h8, 8'h00, 2'd3, 1, "ld_r3_lat");
    check("ld_r3_acc", 32'(acc[0]), 32'hA5);
    check("ld_r3_z",   32'(fz[0]),  32'h0);
    run(0, 4'h6, 8'hFF, 2'd0, 5, "xori_lat");
    check("xori_acc", 32'(acc[0]), 32'h5A);
    check("xori_keep_c", 32'(fc[0]), 32'h1);

    run(0, 4'hF, 8'h00, 2'd0, 1, "out_lat");
    check("out_result", 32'(outr[0]), 32'h5A);
    check("out_valid",  32'(ov[0]),   32'h1);
    @(posedge clk); #1;
    check("out_valid_pulse", 32'(ov[0]), 32'h0);
    check("done_pulse",      32'(dn[0]), 32'h0);

    run(0, 4'h7, 8'h33, 2'd1, 1, "rsv_lat");
    check("rsv_acc", 32'(acc[0]), 32'h5A);

    // Valid held for 12 edges from IDLE: a 6-cycle ADDI admits exactly two accepts
    run(0, 4'h1, 8'h00, 2'd0, 1, "hold_ldi_lat");
    @(posedge clk); #1;
    op = 4'h2; imm = 8'h01; vld[0] = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (dn[0]) ndone++;
    end
    vld[0] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (dn[0]) ndone++;
    end
    check("hold_dones", 32'(ndone),  32'd2);
    check("hold_acc",   32'(acc[0]), 32'h02);
    check("hold_ready", 32'(rdy[0]), 32'h1);

    // Reset during the third EXEC cycle aborts with no done
    run(0, 4'h1, 8'h33, 2'd0, 1, "pre_rst_lat");
    while (!rdy[0]) begin @(posedge clk); #1; end
    op = 4'h2; imm = 8'h11; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(bsy[0]), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_acc",   32'(acc[0]), 32'h0);
    check("abort_ready", 32'(rdy[0]), 32'h1);
    check("abort_done",  32'(dn[0]),  32'h0);
    check("abort_busy",  32'(bsy[0]), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_done", 32'(dn[0]), 32'h0);

    for (int d = 1; d < 3; d++) begin
      alu_lat = (d == 1) ? 9 : 2;
      run(d, 4'h1, 8'h5A, 2'd0, 1, "w_ldi_lat");
      run(d, 4'h2, 8'hC3, 2'd0, alu_lat, "w_addi_lat");
      check("w_addi_acc", 32'(acc[d]), 32'h1D);
      check("w_addi_cz",  32'({fc[d], fz[d]}), 32'b10);
      run(d, 4'h1, 8'h00, 2'd0, 1, "w_ldi0_lat");
      run(d, 4'h3, 8'h01, 2'd0, alu_lat, "w_subi_lat");
      check("w_subi_acc", 32'(acc[d]), 32'hFF);
      check("w_subi_cz",  32'({fc[d], fz[d]}), 32'b00);
      run(d, 4'h1, 8'h10, 2'd0, 1, "w_ldi10_lat");
      run(d, 4'hE, 8'h00, 2'd2, 1, "w_st_lat");
      run(d, 4'hA, 8'h00, 2'd2, alu_lat, "w_sub_lat");
      check("w_sub_acc", 32'(acc[d]), 32'h00);
      check("w_sub_cz",  32'({fc[d], fz[d]}), 32'b11);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
